// File: rtl/vga_timing_if.sv
// Raster timing bundle: counters, active-video enable, syncs and their
// pin-aligned delayed copies, plus line/frame markers.
interface vga_timing_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        enable;
    logic        hsync;
    logic        vsync;
    logic        enable_d;
    logic        hsync_d;
    logic        vsync_d;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output hcount, vcount, enable, hsync, vsync,
        output enable_d, hsync_d, vsync_d,
        output line_start, frame_start, frame_count
    );

    modport slave (
        input hcount, vcount, enable, hsync, vsync,
        input enable_d, hsync_d, vsync_d,
        input line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel counters with aligned enable/syncs,
// one-clock delayed pin copies, and line/frame start markers.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CLK_DIV  = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0]      H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0]      V_LAST   = 12'(V_TOTAL - 1);
    // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
    localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
    localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
    localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_chk
            $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 4096");
        end
        if (CLK_DIV < 1) begin : g_div_chk
            $error("vga_timing: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_ce;
    logic [11:0]      hcount_q, hcount_d;
    logic [11:0]      vcount_q, vcount_d;
    logic             enable_q, enable_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             enable_dly_q, enable_dly_d;
    logic             hsync_dly_q, hsync_dly_d;
    logic             vsync_dly_q, vsync_dly_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_count_q, frame_count_d;

    assign pix_ce = (div_q == DIV_LAST);

    always_comb begin
        div_d    = pix_ce ? '0 : div_q + DIV_W'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_ce) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 12'd1;
            end else begin
                hcount_d = hcount_q + 12'd1;
            end
        end

        // Decoded from the next position so they register in step with the counters
        enable_d = ({1'b0, hcount_d} < H_ACT_END) && ({1'b0, vcount_d} < V_ACT_END);
        hsync_d  = (({1'b0, hcount_d} >= H_SYNC_BEG) && ({1'b0, hcount_d} < H_SYNC_END))
                   ? SYNC_POL : ~SYNC_POL;
        vsync_d  = (({1'b0, vcount_d} >= V_SYNC_BEG) && ({1'b0, vcount_d} < V_SYNC_END))
                   ? SYNC_POL : ~SYNC_POL;

        // Pulses fire only on the clock the position actually changes
        line_start_d  = pix_ce && (hcount_d == 12'd0);
        frame_start_d = line_start_d && (vcount_d == 12'd0);
        frame_count_d = frame_count_q + 16'(frame_start_d);

        enable_dly_d = enable_q;
        hsync_dly_d  = hsync_q;
        vsync_dly_d  = vsync_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            enable_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            enable_dly_q  <= 1'b0;
            hsync_dly_q   <= ~SYNC_POL;
            vsync_dly_q   <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            enable_q      <= enable_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            enable_dly_q  <= enable_dly_d;
            hsync_dly_q   <= hsync_dly_d;
            vsync_dly_q   <= vsync_dly_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.enable      = enable_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.enable_d    = enable_dly_q;
    assign vga.hsync_d     = hsync_dly_q;
    assign vga.vsync_d     = vsync_dly_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: three configurations (small, small with
// a /3 pixel clock, default 640x480) compared cycle by cycle to a position model.
module tb_vga_timing;
    logic clk;
    logic rst_n;

    vga_timing_if s_if ();
    vga_timing_if c_if ();
    vga_timing_if d_if ();

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .CLK_DIV(1)
    ) u_small (.clock(clk), .reset_n(rst_n), .vga(s_if));

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .CLK_DIV(3)
    ) u_div3 (.clock(clk), .reset_n(rst_n), .vga(c_if));

    vga_timing u_def (.clock(clk), .reset_n(rst_n), .vga(d_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        en;
        logic        hs;
        logic        vs;
        logic        en_d;
        logic        hs_d;
        logic        vs_d;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int last_fs_s, last_ls_s, last_ls_c, last_ls_d;
    exp_t sb_s[$], sb_c[$], sb_d[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_cnt, obs, exp);
        end
    endtask

    // Expected outputs after e rising edges with reset released (e=0: in reset)
    function automatic exp_t base(input int e, input int ha, input int hf, input int hsw,
                                  input int hb, input int va, input int vf, input int vsw,
                                  input int vb, input int div, input bit pol);
        exp_t r;
        int ht, vt, k, idx, h, v;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        k  = e / div;
        r.en_d = 1'b0; r.hs_d = 1'b0; r.vs_d = 1'b0;
        if (k == 0) begin
            r.h = 12'(ht - 1); r.v = 12'(vt - 1);
            r.en = 1'b0; r.hs = ~pol; r.vs = ~pol;
            r.ls = 1'b0; r.fs = 1'b0; r.fc = 16'd0;
        end else begin
            idx  = (k - 1) % (ht * vt);
            h    = idx % ht;
            v    = idx / ht;
            r.h  = 12'(h);
            r.v  = 12'(v);
            r.en = (h < ha) && (v < va);
            r.hs = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
            r.vs = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
            r.ls = ((e % div) == 0) && (h == 0);
            r.fs = r.ls && (v == 0);
            r.fc = 16'((k - 1) / (ht * vt) + 1);
        end
        return r;
    endfunction

    function automatic exp_t model(input int e, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vb, input int div, input bit pol);
        exp_t r, p;
        r = base(e, ha, hf, hsw, hb, va, vf, vsw, vb, div, pol);
        p = base((e > 0) ? e - 1 : 0, ha, hf, hsw, hb, va, vf, vsw, vb, div, pol);
        r.en_d = p.en; r.hs_d = p.hs; r.vs_d = p.vs;
        return r;
    endfunction

    function automatic exp_t exp_small(input int e);
        return model(e, 8, 2, 3, 3, 4, 1, 2, 1, 1, 1'b0);
    endfunction
    function automatic exp_t exp_div3(input int e);
        return model(e, 8, 2, 3, 3, 4, 1, 2, 1, 3, 1'b0);
    endfunction
    function automatic exp_t exp_def(input int e);
        return model(e, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0);
    endfunction

    function automatic exp_t obs_small();
        exp_t o;
        o = '{s_if.hcount, s_if.vcount, s_if.enable, s_if.hsync, s_if.vsync, s_if.enable_d,
              s_if.hsync_d, s_if.vsync_d, s_if.line_start, s_if.frame_start, s_if.frame_count};
        return o;
    endfunction
    function automatic exp_t obs_div3();
        exp_t o;
        o = '{c_if.hcount, c_if.vcount, c_if.enable, c_if.hsync, c_if.vsync, c_if.enable_d,
              c_if.hsync_d, c_if.vsync_d, c_if.line_start, c_if.frame_start, c_if.frame_count};
        return o;
    endfunction
    function automatic exp_t obs_def();
        exp_t o;
        o = '{d_if.hcount, d_if.vcount, d_if.enable, d_if.hsync, d_if.vsync, d_if.enable_d,
              d_if.hsync_d, d_if.vsync_d, d_if.line_start, d_if.frame_start, d_if.frame_count};
        return o;
    endfunction

    task automatic compare_exp(input string pfx, input exp_t o, input exp_t x);
        check_eq({pfx, "_hcount"},      32'(o.h),    32'(x.h));
        check_eq({pfx, "_vcount"},      32'(o.v),    32'(x.v));
        check_eq({pfx, "_enable"},      32'(o.en),   32'(x.en));
        check_eq({pfx, "_hsync"},       32'(o.hs),   32'(x.hs));
        check_eq({pfx, "_vsync"},       32'(o.vs),   32'(x.vs));
        check_eq({pfx, "_enable_d"},    32'(o.en_d), 32'(x.en_d));
        check_eq({pfx, "_hsync_d"},     32'(o.hs_d), 32'(x.hs_d));
        check_eq({pfx, "_vsync_d"},     32'(o.vs_d), 32'(x.vs_d));
        check_eq({pfx, "_line_start"},  32'(o.ls),   32'(x.ls));
        check_eq({pfx, "_frame_start"}, 32'(o.fs),   32'(x.fs));
        check_eq({pfx, "_frame_count"}, 32'(o.fc),   32'(x.fc));
    endtask

    task automatic pop_compare(input string pfx, inout exp_t q[$], input exp_t o);
        if (q.size() == 0) begin
            check_eq({pfx, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            compare_exp(pfx, o, q.pop_front());
        end
    endtask

    task automatic clear_trackers();
        last_fs_s = -1; last_ls_s = -1; last_ls_c = -1; last_ls_d = -1;
    endtask

    // One clock: push the model's prediction, then sample 1 time unit after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edge_cnt++;
            sb_s.push_back(exp_small(edge_cnt));
            sb_c.push_back(exp_div3(edge_cnt));
            sb_d.push_back(exp_def(edge_cnt));
            #1;
            pop_compare("s", sb_s, obs_small());
            pop_compare("c", sb_c, obs_div3());
            pop_compare("d", sb_d, obs_def());
            if (s_if.line_start === 1'b1) begin
                $display("line edge=%0d v=%0d frame_count=%0d", edge_cnt, s_if.vcount, s_if.frame_count);
                if (last_ls_s >= 0) check_eq("s_line_period", 32'(edge_cnt - last_ls_s), 32'd16);
                last_ls_s = edge_cnt;
            end
            if (s_if.frame_start === 1'b1) begin
                if (last_fs_s >= 0) check_eq("s_frame_period", 32'(edge_cnt - last_fs_s), 32'd128);
                last_fs_s = edge_cnt;
            end
            if (c_if.line_start === 1'b1) begin
                if (last_ls_c >= 0) check_eq("c_line_period", 32'(edge_cnt - last_ls_c), 32'd48);
                last_ls_c = edge_cnt;
            end
            if (d_if.line_start === 1'b1) begin
                if (last_ls_d >= 0) check_eq("d_line_period", 32'(edge_cnt - last_ls_d), 32'd800);
                last_ls_d = edge_cnt;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        compare_exp({tag, "_s"}, obs_small(), exp_small(0));
        compare_exp({tag, "_c"}, obs_div3(),  exp_div3(0));
        compare_exp({tag, "_d"}, obs_def(),   exp_def(0));
    endtask

    initial begin
        clear_trackers();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_async");
        @(negedge clk);
        check_reset_state("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // First pixel after release, then the pixel after it
        step(1);
        check_eq("s_first_fc", 32'(s_if.frame_count), 32'd1);
        step(1);
        check_eq("s_second_h", 32'(s_if.hcount), 32'd1);

        // Three small frames in total
        step(3 * 128 - 2);
        check_eq("s_fc_after_3_frames", 32'(s_if.frame_count), 32'd3);

        // Advance into frame 4 to position (5,2), then reset between edges
        step(38);
        check_eq("s_pre_reset_h", 32'(s_if.hcount), 32'd5);
        check_eq("s_pre_reset_v", 32'(s_if.vcount), 32'd2);
        #1 rst_n = 1'b0;
        #1 check_reset_state("rst_mid");
        edge_cnt = 0;
        clear_trackers();
        sb_s.delete(); sb_c.delete(); sb_d.delete();
        @(negedge clk);
        check_reset_state("rst_mid_hold");
        @(negedge clk);
        rst_n = 1'b1;

        step(1);
        check_eq("s_restart_h",  32'(s_if.hcount), 32'd0);
        check_eq("s_restart_v",  32'(s_if.vcount), 32'd0);
        check_eq("s_restart_fc", 32'(s_if.frame_count), 32'd1);

        // Two full lines of the default timing plus margin
        step(1700);
        check_eq("d_line_index", 32'(d_if.vcount), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
